// File: rtl/control_pkg.sv
// Shared constants for the user-control front end: button indices and default timing.
package control_pkg;

  localparam int BTN_REC  = 0;
  localparam int BTN_PLAY = 1;
  localparam int BTN_MIX  = 2;
  localparam int BTN_STOP = 3;
  localparam int N_BTN    = 4;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES     = 50000000;
  localparam int DEF_N_SW            = 18;

  // One width serves both debounce and hold counters so neither can wrap.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser, debounce counter, registered press/release pulses and a
// single long-hold pulse per press.
module debounce_channel
  import control_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          hcnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      if (sync == o_level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        o_level   <= sync;
        o_press   <= sync;
        o_release <= ~sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // hcnt parks at HOLD_CYCLES after firing so the pulse cannot repeat within one press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hcnt   <= '0;
      o_hold <= 1'b0;
    end else begin
      o_hold <= 1'b0;
      if (!o_level) begin
        hcnt <= '0;
      end else if (hcnt == HOLD_LAST) begin
        o_hold <= 1'b1;
        hcnt   <= HOLD_SAT;
      end else if (hcnt < HOLD_LAST) begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_conditioner.sv
// Conditions the four command buttons (onboard keys or gpio) and the slide switches
// into clean levels, one-cycle event pulses and a debounced switch vector.
module input_event_conditioner
  import control_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int N_SW            = DEF_N_SW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_key,
  input  logic [11:0]     i_gpio,
  input  logic [N_SW-1:0] i_sw,
  input  logic            i_src_gpio,
  output logic [3:0]      o_key_level,
  output logic [3:0]      o_key_press,
  output logic [3:0]      o_key_release,
  output logic [3:0]      o_key_hold,
  output logic [N_SW-1:0] o_sw_stable,
  output logic            o_sw_changed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] key_raw;
  logic             gpio_unused;

  assign gpio_unused = ^i_gpio[7:0];

  // Source select and polarity fix happen before synchronisation, so a source swap is
  // debounced like any other input change.
  always_comb begin
    key_raw           = '0;
    key_raw[BTN_REC]  = i_src_gpio ? i_gpio[11] : ~i_key[BTN_REC];
    key_raw[BTN_PLAY] = i_src_gpio ? i_gpio[10] : ~i_key[BTN_PLAY];
    key_raw[BTN_MIX]  = i_src_gpio ? i_gpio[9]  : ~i_key[BTN_MIX];
    key_raw[BTN_STOP] = i_src_gpio ? i_gpio[8]  : ~i_key[BTN_STOP];
  end

  for (genvar k = 0; k < N_BTN; k++) begin : g_key
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (key_raw[k]),
      .o_level  (o_key_level[k]),
      .o_press  (o_key_press[k]),
      .o_release(o_key_release[k]),
      .o_hold   (o_key_hold[k])
    );
  end

  logic [SYNC_STAGES-1:0][N_SW-1:0] sw_pipe;
  logic [N_SW-1:0]                  sw_sync;
  logic                             sw_moving;
  logic [CW-1:0]                    sw_cnt;

  // The last stage is the previous-cycle copy of the stage before it, so comparing the
  // two flags a vector change without an extra history register.
  assign sw_sync   = sw_pipe[SYNC_STAGES-1];
  assign sw_moving = (sw_pipe[SYNC_STAGES-2] != sw_sync);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_pipe <= '0;
    end else begin
      sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], i_sw};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_cnt       <= '0;
      o_sw_stable  <= '0;
      o_sw_changed <= 1'b0;
    end else begin
      o_sw_changed <= 1'b0;
      if (sw_moving || (sw_sync == o_sw_stable)) begin
        sw_cnt <= '0;
      end else if (sw_cnt == DB_LAST) begin
        o_sw_stable  <= sw_sync;
        o_sw_changed <= 1'b1;
        sw_cnt       <= '0;
      end else begin
        sw_cnt <= sw_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_event_conditioner.sv
// Bench for input_event_conditioner: directed scenarios plus random stimulus against a
// window-based reference model of debounce, pulse and hold behaviour.
module tb_input_event_conditioner;

  localparam int SS  = 2;
  localparam int D   = 8;
  localparam int HC  = 32;
  localparam int NSW = 18;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     key;
  logic [11:0]    gpio;
  logic [NSW-1:0] sw;
  logic           src;
  logic [3:0]     lvl, prs, rel, hld;
  logic [NSW-1:0] sws;
  logic           swc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_event_conditioner #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HC), .N_SW(NSW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_gpio(gpio), .i_sw(sw),
    .i_src_gpio(src), .o_key_level(lvl), .o_key_press(prs),
    .o_key_release(rel), .o_key_hold(hld), .o_sw_stable(sws), .o_sw_changed(swc)
  );

  // Reference model: raw-sample history, one entry per clock edge since reset.
  logic [3:0]     kq[$];
  logic [NSW-1:0] sq[$];
  logic [3:0]     m_lvl, e_press, e_rel, e_hold;
  logic [NSW-1:0] m_sw;
  logic           e_chg;
  int             rise[4];
  int             nedge;
  int             press_tot[4], hold_tot[4];
  int             chg_tot, sw1_tot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    sq.delete();
    for (int i = 0; i < D + 2; i++) begin
      kq.push_back(4'h0);
      sq.push_back('0);
    end
    m_lvl = '0; m_sw = '0;
    e_press = '0; e_rel = '0; e_hold = '0; e_chg = 1'b0;
    nedge = 0;
    for (int k = 0; k < 4; k++) rise[k] = 0;
  endtask

  // A key level follows the raw value once D consecutive synchronised samples agree;
  // the switch vector additionally needs the sample entering the synchroniser to agree.
  task automatic model_step();
    logic [3:0]     kr, nl;
    logic [NSW-1:0] sv;
    bit             same;
    int             sz;
    nedge++;
    kr = src ? {gpio[8], gpio[9], gpio[10], gpio[11]} : ~key;
    kq.push_back(kr);
    sq.push_back(sw);
    if (kq.size() > D + 3) void'(kq.pop_front());
    if (sq.size() > D + 3) void'(sq.pop_front());
    sz = kq.size();
    nl = m_lvl;
    for (int k = 0; k < 4; k++) begin
      same = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (kq[sz-1-j][k] != kq[sz-3][k]) same = 1'b0;
      e_hold[k] = m_lvl[k] && ((nedge - rise[k]) == HC);
      if (same) nl[k] = kq[sz-3][k];
      if (nl[k] && !m_lvl[k]) rise[k] = nedge;
    end
    e_press = nl & ~m_lvl;
    e_rel   = m_lvl & ~nl;
    m_lvl   = nl;
    sv = sq[sz-2];
    same = 1'b1;
    for (int j = 1; j <= D + 1; j++)
      if (sq[sz-1-j] != sv) same = 1'b0;
    e_chg = same && (sv != m_sw);
    if (e_chg) m_sw = sv;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    chk("level",   32'(lvl), 32'(m_lvl));
    chk("press",   32'(prs), 32'(e_press));
    chk("release", 32'(rel), 32'(e_rel));
    chk("hold",    32'(hld), 32'(e_hold));
    chk("sw_stable",  32'(sws), 32'(m_sw));
    chk("sw_changed", 32'(swc), 32'(e_chg));
    for (int k = 0; k < 4; k++) begin
      press_tot[k] += int'(prs[k]);
      hold_tot[k]  += int'(hld[k]);
    end
    chg_tot += int'(swc);
    if (sws == 18'h00001) sw1_tot++;
  endtask

  // Event bit map: [3:0] press, [7:4] release, [11:8] hold, [12] sw_changed.
  task automatic edges_until(input int b, input int budget, output int e);
    logic [12:0] ev;
    e = -1;
    for (int i = 1; i <= budget && e < 0; i++) begin
      cyc();
      ev = {swc, hld, rel, prs};
      if (ev[b]) e = i;
    end
  endtask

  initial begin
    int e, ep, es, base, base2;
    int idx;
    rst = 1'b1; key = 4'hF; gpio = '0; sw = '0; src = 1'b0;
    chg_tot = 0; sw1_tot = 0;
    for (int k = 0; k < 4; k++) begin press_tot[k] = 0; hold_tot[k] = 0; end
    model_reset();
    repeat (3) cyc();
    chk("rst_level", 32'(lvl), 32'h0);
    chk("rst_sw", 32'(sws), 32'h0);

    // Single press then release on REC.
    rst = 1'b0; key = 4'b1110;
    base = press_tot[0];
    edges_until(0, 30, e);
    chk("s1_press_lat", 32'(e), 32'd10);
    chk("s1_level_vec", 32'(lvl), 32'h1);
    chk("s1_press_vec", 32'(prs), 32'h1);
    repeat (5) cyc();
    chk("s1_press_once", 32'(press_tot[0] - base), 32'd1);
    key = 4'hF;
    edges_until(4, 30, e);
    chk("s1_rel_lat", 32'(e), 32'd10);
    repeat (5) cyc();

    // Bouncing PLAY: toggles every 3 cycles, then settles low.
    base = press_tot[1];
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key[1] = ~key[1];
      cyc();
    end
    key[1] = 1'b0;
    edges_until(1, 30, e);
    chk("s2_press_lat", 32'(e), 32'd10);
    repeat (15) cyc();
    chk("s2_press_once", 32'(press_tot[1] - base), 32'd1);
    key[1] = 1'b1;
    repeat (20) cyc();

    // Long hold on STOP.
    base = hold_tot[3];
    key[3] = 1'b0;
    edges_until(3, 30, e);
    chk("s3_press_lat", 32'(e), 32'd10);
    edges_until(11, 60, e);
    chk("s3_hold_lat", 32'(e), 32'd32);
    repeat (18) cyc();
    key[3] = 1'b1;
    repeat (20) cyc();
    chk("s3_hold_once", 32'(hold_tot[3] - base), 32'd1);

    // Two switches moving with a 5-cycle skew.
    base = chg_tot; base2 = sw1_tot;
    sw = 18'h00001;
    repeat (5) cyc();
    sw = 18'h00003;
    repeat (30) cyc();
    chk("s4_chg_once", 32'(chg_tot - base), 32'd1);
    chk("s4_sw_val", 32'(sws), 32'h3);
    chk("s4_no_partial", 32'(sw1_tot - base2), 32'd0);

    // Button source switched to gpio, then back.
    src = 1'b1; gpio[10] = 1'b1;
    edges_until(1, 30, e);
    chk("s5_press_lat", 32'(e), 32'd10);
    chk("s5_press_vec", 32'(prs), 32'h2);
    repeat (5) cyc();
    src = 1'b0;
    edges_until(5, 30, e);
    chk("s5_rel_lat", 32'(e), 32'd10);
    gpio = '0;
    repeat (10) cyc();

    // Async reset while MIX is partway through its debounce interval.
    key[2] = 1'b0;
    repeat (7) cyc();
    #1 rst = 1'b1;
    #1;
    chk("s6_rst_level", 32'(lvl), 32'h0);
    chk("s6_rst_press", 32'(prs), 32'h0);
    chk("s6_rst_sw", 32'(sws), 32'h0);
    chk("s6_rst_chg", 32'(swc), 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    ep = -1; es = -1; base = chg_tot;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (ep < 0 && prs[2]) ep = i;
      if (es < 0 && swc) es = i;
    end
    chk("s6_press_lat", 32'(ep), 32'd10);
    chk("s6_sw_lat", 32'(es), 32'd10);
    chk("s6_chg_once", 32'(chg_tot - base), 32'd1);
    key = 4'hF;
    repeat (20) cyc();

    // Random stimulus with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 29) == 0) key[k] = ~key[k];
      if ($urandom_range(0, 29) == 0) begin
        idx = 8 + int'($urandom_range(0, 3));
        gpio[idx] = ~gpio[idx];
      end
      gpio[7:0] = 8'($urandom);
      if ($urandom_range(0, 299) == 0) src = ~src;
      if ($urandom_range(0, 39) == 0) begin
        idx = int'($urandom_range(0, NSW - 1));
        sw[idx] = ~sw[idx];
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
